pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage pipeline.
- Drives the enable and flush/bubble controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Arbitrates three stall sources in fixed priority: data-memory wait, taken-branch flush, load-use hazard.
- Bounds data-memory waits with a timeout that parks the pipeline in an error state.

---
 rtl/pipe_hazard_ctrl.sv | 149 ++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait, branch flush,
// load-use bubble, memory timeout. Optional counter: PIPE_HAZARD_PERF_EN.
// Ports: clk, rst (async high); ID/EX hazard fields; ex_branch_taken;
//        mem_req/mem_ready; per-register enables and flushes; timeout_err;
//        stall_cycles (cycles with pc_en=0 while the counter is built in).
module pipe_hazard_ctrl #(
    parameter int REG_AW      = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_wa,
    input  logic              ex_branch_taken,
    input  logic              mem_req,
    input  logic              mem_ready,
    output logic              pc_en,
    output logic              ifid_en,
    output logic              ifid_flush,
    output logic              idex_en,
    output logic              idex_flush,
    output logic              exmem_en,
    output logic              memwb_bubble,
    output logic              timeout_err,
    output logic [31:0]       stall_cycles
);

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        ERR
    } state_t;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t     state_q, state_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       terr_q, terr_d;
    logic       load_use;
    logic       hold;

    assign load_use = ex_memread && (ex_wa != '0) &&
                      ((id_use_rs && (id_rs == ex_wa)) ||
                       (id_use_rt && (id_rt == ex_wa)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            terr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            terr_q     <= terr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        terr_d     = terr_q;
        hold       = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mem_req && !mem_ready) begin
                    hold       = 1'b1;
                    state_d    = MEM_WAIT;
                    wait_cnt_d = 8'd1;
                end
            end
            MEM_WAIT: begin
                if (mem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else begin
                    hold = 1'b1;
                    if (wait_cnt_q == TMO) begin
                        state_d = ERR;
                        terr_d  = 1'b1;
                    end else if (wait_cnt_q != 8'hFF) begin
                        wait_cnt_d = wait_cnt_q + 8'd1;
                    end
                end
            end
            ERR: begin
                hold = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Priority: reset, memory hold, branch squash (drops load-use), bubble.
    always_comb begin
        pc_en        = 1'b1;
        ifid_en      = 1'b1;
        ifid_flush   = 1'b0;
        idex_en      = 1'b1;
        idex_flush   = 1'b0;
        exmem_en     = 1'b1;
        memwb_bubble = 1'b0;
        if (rst) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            ifid_flush   = 1'b1;
            idex_flush   = 1'b1;
            memwb_bubble = 1'b1;
        end else if (hold) begin
            pc_en        = 1'b0;
            ifid_en      = 1'b0;
            idex_en      = 1'b0;
            exmem_en     = 1'b0;
            memwb_bubble = 1'b1;
        end else if (ex_branch_taken) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (load_use) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
        end
    end

    assign timeout_err = terr_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
        end else if (!pc_en) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl with MEM_TIMEOUT=4.
// Driver pushes hand-computed expectations; negedge monitor compares.
module tb_pipe_hazard_ctrl;

    // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble}
    localparam logic [6:0] C_RUN = 7'b1101010;
    localparam logic [6:0] C_STL = 7'b0000001;
    localparam logic [6:0] C_BR  = 7'b1111110;
    localparam logic [6:0] C_LU  = 7'b0001110;
    localparam logic [6:0] C_RST = 7'b0010101;

`ifdef PIPE_HAZARD_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct {
        logic [6:0]  c;
        logic        t;
        logic [31:0] sc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] id_rs = '0, id_rt = '0, ex_wa = '0;
    logic id_use_rs = 0, id_use_rt = 0, ex_memread = 0;
    logic ex_branch_taken = 0, mem_req = 0, mem_ready = 0;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, memwb_bubble, timeout_err;
    logic [31:0] stall_cycles;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int stalls = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .MEM_TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .ex_memread(ex_memread), .ex_wa(ex_wa),
        .ex_branch_taken(ex_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_en(idex_en), .idex_flush(idex_flush),
        .exmem_en(exmem_en), .memwb_bubble(memwb_bubble),
        .timeout_err(timeout_err), .stall_cycles(stall_cycles)
    );

    task automatic v(input logic r,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic urs, input logic urt,
                     input logic mr, input logic [4:0] wa,
                     input logic br, input logic mq, input logic my,
                     input logic [6:0] ec, input logic et);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; id_rs = rs; id_rt = rt;
        id_use_rs = urs; id_use_rt = urt;
        ex_memread = mr; ex_wa = wa;
        ex_branch_taken = br; mem_req = mq; mem_ready = my;
        if (r) stalls = 0;
        e.c  = ec;
        e.t  = et;
        e.sc = PERF ? 32'(stalls) : 32'd0;
        q.push_back(e);
        if (!r && !ec[6]) stalls++;
    endtask

    task automatic idle(input logic [6:0] ec, input logic et);
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, ec, et);
    endtask

    task automatic mw(input logic my, input logic br,
                      input logic [6:0] ec, input logic et);
        v(0, 0, 0, 0, 0, 0, 0, br, 1, my, ec, et);
    endtask

    always @(negedge clk) begin
        exp_t e;
        logic [6:0] a;
        if (q.size() > 0) begin
            e = q.pop_front();
            a = {pc_en, ifid_en, ifid_flush, idex_en,
                 idex_flush, exmem_en, memwb_bubble};
            checks++;
            if (a !== e.c) begin
                failures++;
                $display("FAIL ctrl @%0t got=%b want=%b", $time, a, e.c);
            end
            checks++;
            if (timeout_err !== e.t) begin
                failures++;
                $display("FAIL timeout_err @%0t got=%b want=%b",
                         $time, timeout_err, e.t);
            end
            checks++;
            if (stall_cycles !== e.sc) begin
                failures++;
                $display("FAIL stall_cycles @%0t got=%0d want=%0d",
                         $time, stall_cycles, e.sc);
            end
        end
    end

    initial begin
        int n;
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0);
        idle(C_RUN, 0);
        // load-use on rs, one bubble only
        v(0, 8, 0, 1, 0, 1, 8, 0, 0, 0, C_LU, 0);
        idle(C_RUN, 0);
        // r0 never hazards; unused rt never hazards
        v(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, C_RUN, 0);
        v(0, 3, 9, 1, 0, 1, 9, 0, 0, 0, C_RUN, 0);
        v(0, 3, 9, 1, 1, 1, 9, 0, 0, 0, C_LU, 0);
        // branch squashes simultaneous load-use
        v(0, 8, 0, 1, 0, 1, 8, 1, 0, 0, C_BR, 0);
        idle(C_RUN, 0);
        // three-cycle memory wait
        mw(0, 0, C_STL, 0);
        mw(0, 0, C_STL, 0);
        mw(0, 0, C_STL, 0);
        mw(1, 0, C_RUN, 0);
        idle(C_RUN, 0);
        // zero-wait access and stray ready
        mw(1, 0, C_RUN, 0);
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_RUN, 0);
        // branch ignored while waiting, honoured on ready cycle
        mw(0, 1, C_STL, 0);
        mw(1, 1, C_BR, 0);
        idle(C_RUN, 0);
        // timeout: 1 entry cycle + 4 MEM_WAIT cycles, then ERR
        for (int i = 0; i < 5; i++) mw(0, 0, C_STL, 0);
        mw(0, 0, C_STL, 1);
        v(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, C_STL, 1);
        idle(C_STL, 1);
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0);
        idle(C_RUN, 0);
        // reset mid-wait returns straight to RUN
        mw(0, 0, C_STL, 0);
        mw(0, 0, C_STL, 0);
        v(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, C_RST, 0);
        idle(C_RUN, 0);
        // counter: one load-use bubble + three wait cycles = 4
        v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, C_RST, 0);
        idle(C_RUN, 0);
        v(0, 5, 0, 1, 0, 1, 5, 0, 0, 0, C_LU, 0);
        idle(C_RUN, 0);
        mw(0, 0, C_STL, 0);
        mw(0, 0, C_STL, 0);
        mw(0, 0, C_STL, 0);
        mw(1, 0, C_RUN, 0);
        idle(C_RUN, 0);
        idle(C_RUN, 0);
        n = 0;
        while (q.size() > 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
